multadd_seq_ctrl: RTL and testbench

//  Sequencer that time-multiplexes one MultAdd unit (out = X*W0 + b, signed Qm.f)
//  to compute a gate pre-activation: result = bias + sum_{i<len} W[i]*x[i].

---
 rtl/multadd_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_multadd_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multadd_seq_ctrl.sv
// Sequencer that streams W[i]/x[i] pairs through one external MultAdd unit,
// feeding its output back as the b operand to accumulate bias + sum W[i]*x[i].
module multadd_seq_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    input  logic [DATA_WIDTH-1:0] x_rdata,
    output logic [DATA_WIDTH-1:0] ma_x,
    output logic [DATA_WIDTH-1:0] ma_w,
    output logic [DATA_WIDTH-1:0] ma_b,
    input  logic [DATA_WIDTH-1:0] ma_out,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    // The fixed-point scaling lives in the MultAdd unit; only sanity-check it here.
    if (FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH) begin : g_fract_check
        $error("FRACT_WIDTH must lie in [0, DATA_WIDTH)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [DATA_WIDTH-1:0] result_nxt;
    logic [ADDR_WIDTH:0]   n, n_nxt;
    logic [ADDR_WIDTH:0]   issued, issued_nxt;
    logic [ADDR_WIDTH:0]   accum_cnt, accum_cnt_nxt;
    logic                  rd_en_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_nxt;
    logic                  v;
    logic [ADDR_WIDTH:0]   len_clamped;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    assign ma_x = x_rdata;
    assign ma_w = w_rdata;
    assign ma_b = acc;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            result    <= '0;
            n         <= '0;
            issued    <= '0;
            accum_cnt <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            v         <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            result    <= result_nxt;
            n         <= n_nxt;
            issued    <= issued_nxt;
            accum_cnt <= accum_cnt_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            v         <= rd_en;
        end
    end

    // The first read is issued straight from IDLE so that rd_en rises the cycle
    // after start; v marks the cycle in which that read's data is on the bus.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        result_nxt    = result;
        n_nxt         = n;
        issued_nxt    = issued;
        accum_cnt_nxt = accum_cnt;
        rd_en_nxt     = 1'b0;
        rd_addr_nxt   = rd_addr;

        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt       = bias;
                    n_nxt         = len_clamped;
                    issued_nxt    = '0;
                    accum_cnt_nxt = '0;
                    if (len_clamped == '0) begin
                        result_nxt = bias;
                        state_nxt  = DONE;
                    end else begin
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = '0;
                        issued_nxt  = {{ADDR_WIDTH{1'b0}}, 1'b1};
                        state_nxt   = RUN;
                    end
                end
            end
            RUN: begin
                if (issued < n) begin
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = issued[ADDR_WIDTH-1:0];
                    issued_nxt  = issued + 1'b1;
                end
                if (v) begin
                    acc_nxt       = ma_out;
                    accum_cnt_nxt = accum_cnt + 1'b1;
                    if (accum_cnt + 1'b1 == n) begin
                        result_nxt = ma_out;
                        state_nxt  = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multadd_seq_ctrl.sv
// Self-checking bench for multadd_seq_ctrl: sync-read memories and a MultAdd
// model around the DUT, table vectors, corner sequences and random runs.
module tb_multadd_seq_ctrl;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   len;
    logic [DW-1:0] bias;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] x_rdata;
    logic [DW-1:0] ma_x;
    logic [DW-1:0] ma_w;
    logic [DW-1:0] ma_b;
    logic [DW-1:0] ma_out;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;

    logic [DW-1:0] wmem [DEPTH];
    logic [DW-1:0] xmem [DEPTH];

    int assert_count = 0;
    int fail_count   = 0;

    multadd_seq_ctrl #(
        .DATA_WIDTH (DW),
        .FRACT_WIDTH(FW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .len    (len),
        .bias   (bias),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .w_rdata(w_rdata),
        .x_rdata(x_rdata),
        .ma_x   (ma_x),
        .ma_w   (ma_w),
        .ma_b   (ma_b),
        .ma_out (ma_out),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            w_rdata <= wmem[rd_addr];
            x_rdata <= xmem[rd_addr];
        end
    end

    function automatic logic [DW-1:0] multAdd(input logic [DW-1:0] x, input logic [DW-1:0] w,
                                               input logic [DW-1:0] b);
        logic signed [2*DW-1:0] prod;
        prod = $signed(x) * $signed(w);
        return DW'(prod >>> FW) + b;
    endfunction

    assign ma_out = multAdd(ma_x, ma_w, ma_b);

    // Expected sum straight from the definition: bias + sum of scaled products, mod 2**DW.
    function automatic logic [DW-1:0] modelResult(input int len_in, input logic [DW-1:0] b);
        longint sum;
        int n;
        n = (len_in > DEPTH) ? DEPTH : len_in;
        sum = longint'($signed(b));
        for (int i = 0; i < n; i++) begin
            sum += (longint'($signed(wmem[i])) * longint'($signed(xmem[i]))) >>> FW;
        end
        return sum[DW-1:0];
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic fillMem(input logic [DW-1:0] w, input logic [DW-1:0] x0, input logic [DW-1:0] step);
        for (int i = 0; i < DEPTH; i++) begin
            wmem[i] = w;
            xmem[i] = x0 + DW'(i) * step;
        end
    endtask

    task automatic applyStimulus(input string tag, input int len_in, input logic [DW-1:0] bias_in,
                                 input logic [DW-1:0] exp_res, input int exp_done, input bit hold_start);
        int n;
        int done_cyc;
        int seq_err;
        int busy_err;
        int post_err;
        int reads;
        n        = (len_in > DEPTH) ? DEPTH : len_in;
        done_cyc = -1;
        seq_err  = 0;
        busy_err = 0;
        post_err = 0;
        reads    = 0;
        @(negedge clk);
        start = 1'b1;
        len   = (AW+1)'(len_in);
        bias  = bias_in;
        @(posedge clk);
        #1;
        if (hold_start) begin
            len  = 7'd1;
            bias = 16'hDEAD;
        end else begin
            start = 1'b0;
        end
        for (int cyc = 1; cyc <= 100 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (rd_en === 1'b1) reads++;
            if (rd_en !== (cyc <= n)) seq_err++;
            else if (rd_en === 1'b1 && rd_addr !== AW'(cyc - 1)) seq_err++;
            if (busy !== 1'b1) busy_err++;
            if (done === 1'b1) done_cyc = cyc;
        end
        start = 1'b0;
        checkOutput({tag, ".doneCycle"}, done_cyc, exp_done);
        checkOutput({tag, ".result"}, result, exp_res);
        checkOutput({tag, ".reads"}, reads, n);
        checkOutput({tag, ".rdSequence"}, seq_err, 0);
        checkOutput({tag, ".busyDuringRun"}, busy_err, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || result !== exp_res) post_err++;
        end
        checkOutput({tag, ".idleHold"}, post_err, 0);
    endtask

    typedef struct {
        int            len;
        logic [DW-1:0] bias;
        logic [DW-1:0] w;
        logic [DW-1:0] x0;
        logic [DW-1:0] xstep;
        logic [DW-1:0] exp_res;
        int            exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int rlen;
        logic [DW-1:0] rbias;
        int err;

        vecs[0] = '{3,  16'h0080, 16'h0100, 16'h0100, 16'h0100, 16'h0680, 5};
        vecs[1] = '{0,  16'h1234, 16'h0100, 16'h0100, 16'h0000, 16'h1234, 1};
        vecs[2] = '{2,  16'h0000, 16'h0100, 16'h7F00, 16'h0000, 16'hFE00, 4};
        vecs[3] = '{40, 16'h0000, 16'h0100, 16'h0010, 16'h0000, 16'h0200, 34};
        vecs[4] = '{1,  16'hFFFF, 16'hFF00, 16'h0200, 16'h0000, 16'hFDFF, 3};
        vecs[5] = '{32, 16'h0100, 16'h0080, 16'h0100, 16'h0000, 16'h1100, 34};

        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        bias  = '0;
        fillMem(16'h0, 16'h0, 16'h0);
        #12;
        checkOutput("reset.ctrl", {rd_en, busy, done}, 3'b000);
        checkOutput("reset.rdAddr", rd_addr, 0);
        checkOutput("reset.result", result, 0);
        checkOutput("reset.maB", ma_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fillMem(vecs[i].w, vecs[i].x0, vecs[i].xstep);
            applyStimulus($sformatf("vec%0d", i), vecs[i].len, vecs[i].bias,
                          vecs[i].exp_res, vecs[i].exp_done, 1'b0);
        end

        fillMem(16'h0100, 16'h0100, 16'h0100);
        applyStimulus("startSpam", 4, 16'h0040, 16'h0A40, 6, 1'b1);
        fillMem(16'h0200, 16'h0100, 16'h0000);
        applyStimulus("secondRun", 2, 16'h0000, 16'h0400, 4, 1'b0);

        fillMem(16'h0100, 16'h0100, 16'h0000);
        @(negedge clk);
        start = 1'b1;
        len   = 7'd8;
        bias  = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.ctrl", {rd_en, busy, done}, 3'b000);
        checkOutput("midReset.rdAddr", rd_addr, 0);
        checkOutput("midReset.result", result, 0);
        checkOutput("midReset.maB", ma_b, 0);
        err = 0;
        repeat (4) begin
            @(negedge clk);
            if (rd_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) err++;
        end
        checkOutput("midReset.quiet", err, 0);
        rst_n = 1'b1;
        applyStimulus("afterReset", 8, 16'h0010, 16'h0810, 10, 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wmem[i] = DW'($urandom);
                xmem[i] = DW'($urandom);
            end
            rlen  = $urandom_range(0, 63);
            rbias = DW'($urandom);
            applyStimulus($sformatf("rand%0d", r), rlen, rbias, modelResult(rlen, rbias),
                          (rlen == 0) ? 1 : (((rlen > DEPTH) ? DEPTH : rlen) + 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
